// File: rtl/div_unit_if.sv
// Request/writeback bundle between the execute stage and the iterative divider.
// The master drives operands and control. The slave returns busy and the regfile write.
interface div_unit_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    logic                 start_i;
    logic                 kill_i;
    logic [1:0]           op_i;
    logic [XLEN-1:0]      rs1_data_i;
    logic [XLEN-1:0]      rs2_data_i;
    logic [REG_IDX_W-1:0] rd_idx_i;
    logic                 busy_o;
    logic                 wen_o;
    logic [REG_IDX_W-1:0] rd_idx_o;
    logic [XLEN-1:0]      rd_data_o;

    modport master (
        output start_i, kill_i, op_i, rs1_data_i, rs2_data_i, rd_idx_i,
        input  busy_o, wen_o, rd_idx_o, rd_data_o
    );

    modport slave (
        input  start_i, kill_i, op_i, rs1_data_i, rs2_data_i, rd_idx_i,
        output busy_o, wen_o, rd_idx_o, rd_data_o
    );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU using restoring radix-2 division, one quotient bit per cycle.
// The result is written back through a single-cycle regfile write pulse.
module div_unit #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    div_unit_if.slave  bus
);
    localparam int              CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONE   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MINV  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES  = {XLEN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_wen;
    logic [REG_IDX_W-1:0] r_rd_idx;
    logic [XLEN-1:0]      r_rd_data;
    logic [REG_IDX_W-1:0] r_idx;
    logic                 r_is_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [XLEN-1:0]      r_quo;
    logic [XLEN-1:0]      r_rem;
    logic [XLEN-1:0]      r_div;
    logic [CNT_W-1:0]     r_cnt;

    logic            w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_ge;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_q_fix, w_r_fix, w_res;

    // Negating the most negative value wraps back to 0x80..0, which read as
    // unsigned is exactly its magnitude 2^(XLEN-1).
    assign w_signed = ~bus.op_i[0];
    assign w_a_neg  = w_signed & bus.rs1_data_i[XLEN-1];
    assign w_b_neg  = w_signed & bus.rs2_data_i[XLEN-1];
    assign w_abs_a  = w_a_neg ? (~bus.rs1_data_i + ONE) : bus.rs1_data_i;
    assign w_abs_b  = w_b_neg ? (~bus.rs2_data_i + ONE) : bus.rs2_data_i;

    assign w_div0    = (bus.rs2_data_i == '0);
    assign w_ovf     = w_signed & (bus.rs1_data_i == MINV) & (bus.rs2_data_i == ONES);
    assign w_special = w_div0 ? (bus.op_i[1] ? bus.rs1_data_i : ONES)
                              : (bus.op_i[1] ? '0 : MINV);

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in at the LSB.
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_div};
    assign w_ge     = ~w_diff[XLEN];
    assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

    assign w_q_fix = r_neg_q ? (~w_quo_nx + ONE) : w_quo_nx;
    assign w_r_fix = r_neg_r ? (~w_rem_nx + ONE) : w_rem_nx;
    assign w_res   = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_wen     <= 1'b0;
            r_rd_idx  <= '0;
            r_rd_data <= '0;
            r_idx     <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wen <= 1'b0;
                    if (bus.start_i && !bus.kill_i) begin
                        r_busy   <= 1'b1;
                        r_idx    <= bus.rd_idx_i;
                        r_is_rem <= bus.op_i[1];
                        if (w_div0 || w_ovf) begin
                            r_state   <= S_DONE;
                            r_wen     <= (bus.rd_idx_i != '0);
                            r_rd_idx  <= bus.rd_idx_i;
                            r_rd_data <= w_special;
                        end else begin
                            r_state <= S_CALC;
                            r_quo   <= w_abs_a;
                            r_rem   <= '0;
                            r_div   <= w_abs_b;
                            r_cnt   <= CNT_W'(XLEN);
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.kill_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_quo <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state   <= S_DONE;
                            r_wen     <= (r_idx != '0);
                            r_rd_idx  <= r_idx;
                            r_rd_data <= w_res;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_wen   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.wen_o     = r_wen;
    assign bus.rd_idx_o  = r_rd_idx;
    assign bus.rd_data_o = r_rd_data;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: cycle-accurate writeback timing, signed/unsigned results,
// fast-path special cases, ignored restart, kill and asynchronous reset.
module tb_div_unit;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    div_unit_if #(.XLEN(32), .REG_IDX_W(5)) bus ();
    div_unit #(.XLEN(32), .REG_IDX_W(5)) dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launches one op in cycle 0 and watches cycles 1..40.
    // exp_wen: cycle of the write pulse (0 = no pulse); exp_last: last busy cycle.
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int exp_wen,
                       input logic [31:0] exp_data, input int exp_last,
                       input int poke, input int kill);
        int wen_cyc = 0, wen_cnt = 0, fb = 0, lb = 0, nb = 0;
        bus.op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b; bus.rd_idx_i = rd;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.wen_o) begin wen_cnt++; if (wen_cyc == 0) wen_cyc = k; end
            if (bus.busy_o) begin nb++; if (fb == 0) fb = k; lb = k; end
            if (k == poke) begin
                bus.start_i = 1'b1; bus.op_i = DIVU;
                bus.rs1_data_i = 32'd50; bus.rs2_data_i = 32'd5; bus.rd_idx_i = 5'd9;
            end
            if (k == kill) bus.kill_i = 1'b1;
            @(posedge clk); #1;
            bus.start_i = 1'b0; bus.kill_i = 1'b0;
        end
        chk({tag, ".wen_cyc"}, wen_cyc, exp_wen);
        chk({tag, ".wen_cnt"}, wen_cnt, (exp_wen != 0) ? 1 : 0);
        chk({tag, ".busy_first"}, fb, 1);
        chk({tag, ".busy_last"}, lb, exp_last);
        chk({tag, ".busy_cnt"}, nb, exp_last);
        if (kill == 0) begin
            chk({tag, ".data"}, bus.rd_data_o, exp_data);
            chk({tag, ".idx"}, {27'd0, bus.rd_idx_o}, {27'd0, rd});
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.kill_i = 1'b0; bus.op_i = 2'b00;
        bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.rd_idx_i = '0;
        #12;
        chk("rst.busy", {31'd0, bus.busy_o}, 0);
        chk("rst.wen", {31'd0, bus.wen_o}, 0);
        chk("rst.data", bus.rd_data_o, 0);
        chk("rst.idx", {27'd0, bus.rd_idx_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run("divu_100_7", DIVU, 32'd100, 32'd7, 5'd3, 33, 32'd14, 33, 0, 0);
        run("remu_100_7", REMU, 32'd100, 32'd7, 5'd3, 33, 32'd2, 33, 0, 0);
        run("div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2, 5'd4, 33, 32'hFFFFFFFD, 33, 0, 0);
        run("rem_m7_2",   REM,  32'hFFFFFFF9, 32'd2, 5'd4, 33, 32'hFFFFFFFF, 33, 0, 0);
        run("div_7_m2",   DIV,  32'd7, 32'hFFFFFFFE, 5'd5, 33, 32'hFFFFFFFD, 33, 0, 0);
        run("rem_7_m2",   REM,  32'd7, 32'hFFFFFFFE, 5'd5, 33, 32'd1, 33, 0, 0);
        run("div_min_2",  DIV,  32'h80000000, 32'd2, 5'd6, 33, 32'hC0000000, 33, 0, 0);
        run("divu_5_0",   DIVU, 32'd5, 32'd0, 5'd7, 1, 32'hFFFFFFFF, 1, 0, 0);
        run("remu_5_0",   REMU, 32'd5, 32'd0, 5'd7, 1, 32'd5, 1, 0, 0);
        run("rem_m5_0",   REM,  32'hFFFFFFFB, 32'd0, 5'd7, 1, 32'hFFFFFFFB, 1, 0, 0);
        run("div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 5'd8, 1, 32'h80000000, 1, 0, 0);
        run("rem_ovf",    REM,  32'h80000000, 32'hFFFFFFFF, 5'd8, 1, 32'd0, 1, 0, 0);
        run("restart_ign", DIVU, 32'd100, 32'd7, 5'd3, 33, 32'd14, 33, 5, 0);
        run("kill_c10",   DIVU, 32'd9, 32'd3, 5'd2, 0, 32'd0, 10, 0, 10);
        chk("kill.data_hold", bus.rd_data_o, 32'd14);

        bus.op_i = DIVU; bus.rs1_data_i = 32'd100; bus.rs2_data_i = 32'd7; bus.rd_idx_i = 5'd4;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 1; k < 12; k++) begin @(posedge clk); #1; end
        chk("midrst.busy_before", {31'd0, bus.busy_o}, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", {31'd0, bus.busy_o}, 0);
        chk("midrst.wen", {31'd0, bus.wen_o}, 0);
        chk("midrst.data", bus.rd_data_o, 0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run("post_rst_divu_9_3", DIVU, 32'd9, 32'd3, 5'd5, 33, 32'd3, 33, 0, 0);
        run("rd0_divu_9_3",      DIVU, 32'd9, 32'd3, 5'd0, 0,  32'd3, 33, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
